register_read_unit: RTL and testbench
=====================================

// Module: register_read_unit
// PURPOSE
//  Read side of the CTI-8 register file. Consumes the one-hot write-enable
//  vector produced by the write-select decoder, holds the register storage,
//  and serves two registered read ports (ALU operands A/B) with write-to-read
//  bypass. It also provides a valid/ready debug dump sequencer that streams
//  every register out in index order.
// PARAMETERS
//  DATA_WIDTH  8  register width in bits
//  ADDR_WIDTH  4  select width; NUM_REGS = 2**ADDR_WIDTH (localparam, 16)
// PORTS
//  clk        in   1           single clock; all state updates on rising edge
//  rst        in   1           synchronous, active-high reset
//  wr         in   NUM_REGS    one-hot write enable (bit i writes reg i)
//  wrData     in   DATA_WIDTH  write data
//  rdSelA     in   ADDR_WIDTH  read port A select
//  rdSelB     in   ADDR_WIDTH  read port B select
//  rdA        out  DATA_WIDTH  registered read data A
//  rdB        out  DATA_WIDTH  registered read data B
//  wrError    out  1           1-cycle pulse: previous wr had >1 bit set
//  dumpStart  in   1           start a full-register dump (sampled in IDLE only)
//  dumpBusy   out  1           dump sequence in progress
//  dumpValid  out  1           dumpIndex/dumpData valid
//  dumpReady  in   1           consumer accepts the current dump beat
//  dumpIndex  out  ADDR_WIDTH  register index of the current beat
//  dumpData   out  DATA_WIDTH  register contents of the current beat
// BEHAVIOUR
//  Reset: all registers, rdA, rdB, dumpData and dumpIndex = 0; wrError,
//   dumpValid and dumpBusy = 0; FSM = IDLE. Reset wins over every other input
//   in the same cycle, including mid-dump (the dump is aborted, no further beats).
//  Write: wr == 0 -> no write. Exactly one bit i set -> reg[i] <= wrData.
//   More than one bit set -> no register changes, and wrError = 1 in the next cycle only.
//  Read: 1-cycle latency. rdA <= (legal write to rdSelA this cycle) ? wrData :
//   reg[rdSelA]. rdB uses the same rule. An illegal wr never bypasses.
//  Dump FSM, states IDLE / LOAD / PRESENT:
//   IDLE: dumpBusy=0, dumpValid=0. If dumpStart: dumpIndex<=0, go to LOAD.
//   LOAD: dumpBusy=1, dumpValid=0. Capture dumpData <= reg[dumpIndex], with
//    bypass from a legal same-cycle write. Go to PRESENT.
//   PRESENT: dumpBusy=1, dumpValid=1. dumpIndex/dumpData are held stable while
//    dumpReady=0, even if the register is written meanwhile.
//    On dumpValid&dumpReady: if dumpIndex==NUM_REGS-1 go to IDLE, else
//    dumpIndex<=dumpIndex+1 and go to LOAD.
//   dumpStart is ignored outside IDLE. Each beat takes at least 2 cycles.
//   Writes and reads continue normally during a dump.
//  dumpIndex never wraps. The sequence ends after index NUM_REGS-1.
// STRUCTURE
//  Shared package cti8_pkg: DATA_WIDTH/ADDR_WIDTH constants, the dump-state
//   enum (IDLE, LOAD, PRESENT), and a one-hot check function (onehot/zero/multi).
//  One natural sub-module: onehot_to_index (wr -> {index, legal, multi}),
//   shared by the write, bypass and dump-capture paths.
// TESTING
//  1. After reset: rdA/rdB/dumpData = 0 and no status outputs asserted;
//   rdSelA=5 -> rdA=0x00.
//  2. wr=0x0020, wrData=0xA5, rdSelA=5 in the same cycle -> rdA=0xA5 next cycle
//   (bypass); wr=0 then rdSelB=5 -> rdB=0xA5.
//  3. wr=0x0006, wrData=0xFF -> regs 1/2 unchanged, wrError=1 for exactly
//   one cycle, rdA of reg 1 not 0xFF.
//  4. Preload reg[i]=i+0x10, pulse dumpStart, dumpReady=1 -> 16 beats,
//   index 0..15, data 0x10..0x1F, then dumpBusy=0.
//  5. During a dump, hold dumpReady=0 at beat 3 while writing reg3=0x77 ->
//   beat stays 0x13. Rerun -> beat 3 = 0x77. dumpStart mid-dump -> no restart.
//  6. Assert rst at beat 7 -> dumpValid=0 and dumpBusy=0 next cycle, all regs 0.

Source files
------------

// File: rtl/cti8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cti8_pkg
//  Description : Shared constants, dump-state encoding and one-hot classifier
//                for the CTI-8 register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package cti8_pkg;

    localparam int CTI8_DATA_WIDTH = 8;
    localparam int CTI8_ADDR_WIDTH = 4;
    localparam int CTI8_NUM_REGS   = 2 ** CTI8_ADDR_WIDTH;

    typedef enum logic [1:0] {
        DUMP_IDLE    = 2'd0,
        DUMP_LOAD    = 2'd1,
        DUMP_PRESENT = 2'd2
    } dump_state_t;

    typedef enum logic [1:0] {
        OH_ZERO  = 2'd0,
        OH_ONE   = 2'd1,
        OH_MULTI = 2'd2
    } onehot_kind_t;

    // v & (v-1) clears the lowest set bit; anything left means >1 bit was set.
    function automatic onehot_kind_t onehot_check(input logic [31:0] vec);
        if (vec == 32'd0) begin
            return OH_ZERO;
        end
        if ((vec & (vec - 32'd1)) != 32'd0) begin
            return OH_MULTI;
        end
        return OH_ONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_to_index.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_to_index
//  Description : Converts a write-enable vector into {index, legal, multi}.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_to_index
    import cti8_pkg::*;
#(
    parameter int ADDR_WIDTH = CTI8_ADDR_WIDTH  // up to 5 (classifier is 32 bits)
) (
    input  logic [2**ADDR_WIDTH-1:0] vec_i,
    output logic [ADDR_WIDTH-1:0]    index_o,
    output logic                     legal_o,
    output logic                     multi_o
);

    localparam int NUM = 2 ** ADDR_WIDTH;

    onehot_kind_t          w_kind;
    logic [ADDR_WIDTH-1:0] w_index;

    assign w_kind = onehot_check(32'(vec_i));

    // OR of set-bit positions; exact whenever the vector is one-hot.
    always_comb begin
        w_index = '0;
        for (int i = 0; i < NUM; i++) begin
            if (vec_i[i]) begin
                w_index = w_index | ADDR_WIDTH'(i);
            end
        end
    end

    assign index_o = w_index;
    assign legal_o = (w_kind == OH_ONE);
    assign multi_o = (w_kind == OH_MULTI);

endmodule
`default_nettype wire

// File: rtl/register_read_unit.sv
`default_nettype none
// ============================================================================
//  Module      : register_read_unit
//  Description : CTI-8 register storage with two bypassed read ports and a
//                valid/ready register dump sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_read_unit
    import cti8_pkg::*;
#(
    parameter int DATA_WIDTH = CTI8_DATA_WIDTH,
    parameter int ADDR_WIDTH = CTI8_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2**ADDR_WIDTH-1:0] wr,
    input  logic [DATA_WIDTH-1:0]    wrData,
    input  logic [ADDR_WIDTH-1:0]    rdSelA,
    input  logic [ADDR_WIDTH-1:0]    rdSelB,
    output logic [DATA_WIDTH-1:0]    rdA,
    output logic [DATA_WIDTH-1:0]    rdB,
    output logic                     wrError,
    input  logic                     dumpStart,
    output logic                     dumpBusy,
    output logic                     dumpValid,
    input  logic                     dumpReady,
    output logic [ADDR_WIDTH-1:0]    dumpIndex,
    output logic [DATA_WIDTH-1:0]    dumpData
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(NUM_REGS - 1);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] rdA_q;
    logic [DATA_WIDTH-1:0] rdB_q;
    logic                  wrError_q;

    dump_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] dumpIndex_q, dumpIndex_d;
    logic [DATA_WIDTH-1:0] dumpData_q, dumpData_d;

    logic [ADDR_WIDTH-1:0] w_wr_index;
    logic                  w_wr_legal;
    logic                  w_wr_multi;

    onehot_to_index #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_decode (
        .vec_i   (wr),
        .index_o (w_wr_index),
        .legal_o (w_wr_legal),
        .multi_o (w_wr_multi)
    );

    // Storage: only a legal one-hot write updates a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_legal) begin
            regs_q[w_wr_index] <= wrData;
        end
    end

    // Read ports forward same-cycle legal write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdA_q     <= '0;
            rdB_q     <= '0;
            wrError_q <= 1'b0;
        end else begin
            rdA_q     <= (w_wr_legal && (w_wr_index == rdSelA)) ? wrData : regs_q[rdSelA];
            rdB_q     <= (w_wr_legal && (w_wr_index == rdSelB)) ? wrData : regs_q[rdSelB];
            wrError_q <= w_wr_multi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DUMP_IDLE;
            dumpIndex_q <= '0;
            dumpData_q  <= '0;
        end else begin
            state_q     <= state_d;
            dumpIndex_q <= dumpIndex_d;
            dumpData_q  <= dumpData_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dumpIndex_d = dumpIndex_q;
        dumpData_d  = dumpData_q;
        case (state_q)
            DUMP_IDLE: begin
                if (dumpStart) begin
                    dumpIndex_d = '0;
                    state_d     = DUMP_LOAD;
                end
            end
            DUMP_LOAD: begin
                dumpData_d = (w_wr_legal && (w_wr_index == dumpIndex_q)) ? wrData
                                                                         : regs_q[dumpIndex_q];
                state_d    = DUMP_PRESENT;
            end
            DUMP_PRESENT: begin
                // Beat is frozen until accepted; later writes are not reflected.
                if (dumpReady) begin
                    if (dumpIndex_q == LAST_INDEX) begin
                        state_d = DUMP_IDLE;
                    end else begin
                        dumpIndex_d = dumpIndex_q + 1'b1;
                        state_d     = DUMP_LOAD;
                    end
                end
            end
            default: begin
                state_d = DUMP_IDLE;
            end
        endcase
    end

    assign rdA       = rdA_q;
    assign rdB       = rdB_q;
    assign wrError   = wrError_q;
    assign dumpBusy  = (state_q != DUMP_IDLE);
    assign dumpValid = (state_q == DUMP_PRESENT);
    assign dumpIndex = dumpIndex_q;
    assign dumpData  = dumpData_q;

endmodule
`default_nettype wire

// File: tb/tb_register_read_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_read_unit
//  Description : Directed self-checking bench for register_read_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_read_unit;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NR = 16;

    logic          clk;
    logic          rst;
    logic [NR-1:0] wr;
    logic [DW-1:0] wrData;
    logic [AW-1:0] rdSelA;
    logic [AW-1:0] rdSelB;
    logic [DW-1:0] rdA;
    logic [DW-1:0] rdB;
    logic          wrError;
    logic          dumpStart;
    logic          dumpBusy;
    logic          dumpValid;
    logic          dumpReady;
    logic [AW-1:0] dumpIndex;
    logic [DW-1:0] dumpData;

    int checks = 0;
    int errors = 0;

    register_read_unit #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .wrData    (wrData),
        .rdSelA    (rdSelA),
        .rdSelB    (rdSelB),
        .rdA       (rdA),
        .rdB       (rdB),
        .wrError   (wrError),
        .dumpStart (dumpStart),
        .dumpBusy  (dumpBusy),
        .dumpValid (dumpValid),
        .dumpReady (dumpReady),
        .dumpIndex (dumpIndex),
        .dumpData  (dumpData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until a beat is presented (bounded), then check it.
    task automatic do_beat(input int idx, input logic [DW-1:0] exp);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!dumpValid && n < 8);
        check($sformatf("beat%0d_valid", idx), {15'd0, dumpValid}, 16'd1);
        check($sformatf("beat%0d_index", idx), {12'd0, dumpIndex}, 16'(idx));
        check($sformatf("beat%0d_data", idx), {8'd0, dumpData}, {8'd0, exp});
    endtask

    task automatic write_reg(input int idx, input logic [DW-1:0] d);
        wr     = NR'(1) << idx;
        wrData = d;
        tick();
        wr     = '0;
    endtask

    initial begin
        rst = 1'b1; wr = '0; wrData = '0; rdSelA = '0; rdSelB = '0;
        dumpStart = 1'b0; dumpReady = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_rdA", {8'd0, rdA}, 16'h0);
        check("rst_rdB", {8'd0, rdB}, 16'h0);
        check("rst_dumpData", {8'd0, dumpData}, 16'h0);
        check("rst_dumpIndex", {12'd0, dumpIndex}, 16'h0);
        check("rst_wrError", {15'd0, wrError}, 16'h0);
        check("rst_dumpValid", {15'd0, dumpValid}, 16'h0);
        check("rst_dumpBusy", {15'd0, dumpBusy}, 16'h0);
        rdSelA = 4'd5;
        tick();
        check("rd5_after_rst", {8'd0, rdA}, 16'h00);

        // Bypass on same-cycle write, then plain read
        wr = 16'h0020; wrData = 8'hA5; rdSelA = 4'd5;
        tick();
        check("bypass_rdA", {8'd0, rdA}, 16'h00A5);
        wr = '0; rdSelB = 4'd5;
        tick();
        check("read_rdB", {8'd0, rdB}, 16'h00A5);

        // Illegal multi-bit write
        write_reg(1, 8'h11);
        wr = 16'h0006; wrData = 8'hFF; rdSelA = 4'd1;
        tick();
        check("wrError_set", {15'd0, wrError}, 16'h1);
        check("no_bypass_illegal", {8'd0, rdA}, 16'h0011);
        wr = '0; rdSelB = 4'd2;
        tick();
        check("wrError_pulse", {15'd0, wrError}, 16'h0);
        check("reg1_kept", {8'd0, rdA}, 16'h0011);
        check("reg2_kept", {8'd0, rdB}, 16'h0000);

        // Full dump with consumer always ready
        for (int i = 0; i < NR; i++) write_reg(i, 8'(i + 16'h10));
        dumpReady = 1'b1;
        dumpStart = 1'b1;
        tick();
        dumpStart = 1'b0;
        check("load_busy", {15'd0, dumpBusy}, 16'h1);
        check("load_not_valid", {15'd0, dumpValid}, 16'h0);
        for (int i = 0; i < NR; i++) do_beat(i, 8'(i + 16'h10));
        tick();
        check("dump1_done_busy", {15'd0, dumpBusy}, 16'h0);
        check("dump1_done_valid", {15'd0, dumpValid}, 16'h0);

        // Back-pressure at beat 3 with a write to reg 3 and a stray dumpStart
        dumpStart = 1'b1;
        tick();
        dumpStart = 1'b0;
        for (int i = 0; i < 4; i++) do_beat(i, 8'(i + 16'h10));
        dumpReady = 1'b0;
        wr = 16'h0008; wrData = 8'h77; dumpStart = 1'b1;
        tick();
        wr = '0; dumpStart = 1'b0;
        tick();
        tick();
        check("hold_valid", {15'd0, dumpValid}, 16'h1);
        check("hold_index", {12'd0, dumpIndex}, 16'h3);
        check("hold_data", {8'd0, dumpData}, 16'h13);
        dumpReady = 1'b1;
        for (int i = 4; i < NR; i++) do_beat(i, 8'(i + 16'h10));
        tick();
        check("dump2_done_busy", {15'd0, dumpBusy}, 16'h0);

        // Rerun sees the new reg 3 value
        dumpStart = 1'b1;
        tick();
        dumpStart = 1'b0;
        for (int i = 0; i < NR; i++) do_beat(i, (i == 3) ? 8'h77 : 8'(i + 16'h10));
        tick();

        // Reset mid-dump at beat 7
        dumpStart = 1'b1;
        tick();
        dumpStart = 1'b0;
        for (int i = 0; i < 8; i++) do_beat(i, (i == 3) ? 8'h77 : 8'(i + 16'h10));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", {15'd0, dumpValid}, 16'h0);
        check("abort_busy", {15'd0, dumpBusy}, 16'h0);
        check("abort_index", {12'd0, dumpIndex}, 16'h0);
        check("abort_data", {8'd0, dumpData}, 16'h0);
        for (int i = 0; i < NR; i++) begin
            rdSelA = AW'(i);
            rdSelB = AW'(NR - 1 - i);
            tick();
            check($sformatf("cleared_A%0d", i), {8'd0, rdA}, 16'h0);
            check($sformatf("cleared_B%0d", i), {8'd0, rdB}, 16'h0);
            check($sformatf("no_beat_%0d", i), {15'd0, dumpValid}, 16'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
